// File: rtl/bin_peak_decay.sv
// bin_peak_decay: per-bin FFT energy level meter with a two-stage pipeline (square/sum, scale/write).
// Define BIN_PEAK_DECAY_PEAK_HOLD_EN for peak-hold levels with periodic decay; default writes levels directly.
module bin_peak_decay #(
    parameter int WIDTH      = 12,
    parameter int BINS       = 8,
    parameter int BIN_DIV    = 7,
    parameter int DECAY_DIV  = 4,
    parameter int DECAY_STEP = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    sync,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    output logic [8*BINS-1:0]       levels,
    output logic                    frame_done
);
    localparam int IW = $clog2(BINS + 1);
    localparam int EW = 2 * WIDTH;

    if (BINS < 1 || BINS > 255 || DECAY_DIV < 1 || DECAY_STEP < 0 || DECAY_STEP > 255 ||
        BIN_DIV < 0 || WIDTH < 4) begin : g_param_check
        $error("bin_peak_decay: parameter out of range");
    end

    logic [IW-1:0]        r_idx;
    logic                 r_seen;
    logic                 r_v1;
    logic [IW-1:0]        r_idx1;
    logic [EW-1:0]        r_energy;
    logic [7:0]           r_level [BINS];
    logic                 r_frame_done;

    logic signed [EW-1:0] w_re_sq;
    logic signed [EW-1:0] w_im_sq;
    logic [EW-1:0]        w_energy;
    logic [IW-1:0]        w_cur_idx;
    logic                 w_valid;
    logic [EW-1:0]        w_shift;
    logic [7:0]           w_scaled;
    logic [7:0]           w_next [BINS];

    assign w_re_sq   = EW'(in_real) * EW'(in_real);
    assign w_im_sq   = EW'(in_imag) * EW'(in_imag);
    assign w_energy  = $unsigned(w_re_sq) + $unsigned(w_im_sq);
    // r_idx == BINS marks "no valid frame position" (after reset or past the last bin)
    assign w_cur_idx = sync ? '0 : r_idx;
    assign w_valid   = ce && (sync || r_seen) && (w_cur_idx < IW'(BINS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx    <= IW'(BINS);
            r_seen   <= 1'b0;
            r_v1     <= 1'b0;
            r_idx1   <= '0;
            r_energy <= '0;
        end else begin
            r_v1 <= w_valid;
            if (ce) begin
                r_idx    <= (w_cur_idx == IW'(BINS)) ? w_cur_idx : w_cur_idx + 1'b1;
                r_idx1   <= w_cur_idx;
                r_energy <= w_energy;
                if (sync) begin
                    r_seen <= 1'b1;
                end
            end
        end
    end

    assign w_shift  = r_energy >> BIN_DIV;
    assign w_scaled = (w_shift > EW'(255)) ? 8'hFF : w_shift[7:0];

`ifdef BIN_PEAK_DECAY_PEAK_HOLD_EN
    localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [DW-1:0] r_dcnt;
    logic          w_decay;

    assign w_decay = ce && sync && (r_dcnt == DW'(DECAY_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dcnt <= '0;
        end else if (ce && sync) begin
            r_dcnt <= w_decay ? '0 : r_dcnt + 1'b1;
        end
    end

    // decay first, then the write can only raise the level
    always_comb begin
        for (int k = 0; k < BINS; k++) begin
            w_next[k] = r_level[k];
            if (w_decay) begin
                w_next[k] = (r_level[k] > 8'(DECAY_STEP)) ? r_level[k] - 8'(DECAY_STEP) : 8'd0;
            end
            if (r_v1 && (r_idx1 == IW'(k)) && (w_scaled > w_next[k])) begin
                w_next[k] = w_scaled;
            end
        end
    end
`else
    always_comb begin
        for (int k = 0; k < BINS; k++) begin
            w_next[k] = r_level[k];
            if (r_v1 && (r_idx1 == IW'(k))) begin
                w_next[k] = w_scaled;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < BINS; k++) begin
                r_level[k] <= '0;
            end
            r_frame_done <= 1'b0;
        end else begin
            for (int k = 0; k < BINS; k++) begin
                r_level[k] <= w_next[k];
            end
            r_frame_done <= r_v1 && (r_idx1 == IW'(BINS - 1));
        end
    end

    for (genvar k = 0; k < BINS; k++) begin : g_levels
        assign levels[8*k +: 8] = r_level[k];
    end

    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bin_peak_decay.sv
// Directed bench for bin_peak_decay: vector table for the first frame, then hand sequences
// for decay, same-edge decay/write, and reset mid-frame. Follows BIN_PEAK_DECAY_PEAK_HOLD_EN.
module tb_bin_peak_decay;
    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               sync;
    logic signed [11:0] in_real;
    logic signed [11:0] in_imag;
    logic [63:0]        levels;
    logic               frame_done;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;
    logic signed [11:0] fr_re [8];

    typedef struct {
        logic               ce;
        logic               sync;
        logic signed [11:0] re;
        logic signed [11:0] im;
        int                 bin;
        logic [7:0]         exp_lvl;
        logic               exp_fd;
    } vec_t;

    vec_t vt [13];

    always #5 clk = ~clk;

    bin_peak_decay #(
        .WIDTH(12), .BINS(8), .BIN_DIV(7), .DECAY_DIV(4), .DECAY_STEP(1)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .sync(sync),
        .in_real(in_real), .in_imag(in_imag),
        .levels(levels), .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1; ce = 1'b0; sync = 1'b0; in_real = '0; in_imag = '0;
        step();
        step();
        reset = 1'b0;
        fd_cnt = 0;
    endtask

    task automatic send_frame(input bit idle);
        for (int k = 0; k < 8; k++) begin
            ce = 1'b1; sync = (k == 0); in_real = fr_re[k]; in_imag = '0;
            step();
        end
        ce = 1'b0; sync = 1'b0; in_real = '0;
        if (idle) begin
            step();
            step();
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 8; k++) fr_re[k] = '0;
    endtask

    function automatic logic [63:0] bin_of(input logic [63:0] lv, input int b);
        return 64'(lv[8*b +: 8]);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0,  12'sd2047,     12'sd0, 0, 8'd0,   1'b0};
        vt[1]  = '{1'b1, 1'b0,  12'sd2047,  12'sd2047, 0, 8'd0,   1'b0};
        vt[2]  = '{1'b1, 1'b1,   12'sd100,     12'sd0, 0, 8'd0,   1'b0};
        vt[3]  = '{1'b1, 1'b0,  -12'sd100,     12'sd0, 0, 8'd78,  1'b0};
        vt[4]  = '{1'b1, 1'b0,  12'sd2047,  12'sd2047, 1, 8'd78,  1'b0};
        vt[5]  = '{1'b1, 1'b0, -12'sd2048, -12'sd2048, 2, 8'd255, 1'b0};
        vt[6]  = '{1'b1, 1'b0,     12'sd0,    12'sd50, 3, 8'd255, 1'b0};
        vt[7]  = '{1'b1, 1'b0,    12'sd16,     12'sd0, 4, 8'd19,  1'b0};
        vt[8]  = '{1'b1, 1'b0,     12'sd0,   -12'sd40, 5, 8'd2,   1'b0};
        vt[9]  = '{1'b1, 1'b0,    12'sd30,    12'sd30, 6, 8'd12,  1'b0};
        vt[10] = '{1'b1, 1'b0,  12'sd2047,     12'sd0, 7, 8'd14,  1'b1};
        vt[11] = '{1'b0, 1'b0,     12'sd0,     12'sd0, 0, 8'd78,  1'b0};
        vt[12] = '{1'b0, 1'b0,     12'sd0,     12'sd0, 7, 8'd14,  1'b0};

        reset = 1'b1; ce = 1'b0; sync = 1'b0; in_real = '0; in_imag = '0;
        step();
        step();
        check("reset levels", levels, 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        fd_cnt = 0;

        for (int i = 0; i < 13; i++) begin
            ce = vt[i].ce; sync = vt[i].sync; in_real = vt[i].re; in_imag = vt[i].im;
            step();
            check($sformatf("vec%0d level bin%0d", i, vt[i].bin), bin_of(levels, vt[i].bin),
                  64'(vt[i].exp_lvl));
            check($sformatf("vec%0d frame_done", i), 64'(frame_done), 64'(vt[i].exp_fd));
        end
        check("frame1 all levels", levels, 64'h0E0C_0213_FFFF_4E4E);
        check("frame1 frame_done count", 64'(fd_cnt), 64'd1);

        clear_frame();
`ifdef BIN_PEAK_DECAY_PEAK_HOLD_EN
        for (int n = 2; n <= 316; n++) begin
            fd_cnt = 0;
            send_frame(1'b1);
            if (n == 2) check("decay frame_done count", 64'(fd_cnt), 64'd1);
            if (n == 3) check("hold after 3 syncs", bin_of(levels, 0), 64'd78);
            if (n == 4) check("decay on 4th sync", bin_of(levels, 0), 64'd77);
            if (n == 8) check("decay on 8th sync", bin_of(levels, 0), 64'd76);
            if (n == 311) check("decay near zero", bin_of(levels, 0), 64'd1);
            if (n == 312) check("decay reaches zero", bin_of(levels, 0), 64'd0);
            if (n == 316) check("decay holds zero", bin_of(levels, 0), 64'd0);
        end

        do_reset();
        clear_frame(); fr_re[7] = 12'sd80;
        send_frame(1'b1);
        check("setup bin7=50", bin_of(levels, 7), 64'd50);
        fr_re[7] = 12'sd0;  send_frame(1'b1);
        fr_re[7] = 12'sd36; send_frame(1'b0);
        fr_re[7] = 12'sd0;  send_frame(1'b1);
        check("decay+write at 50", bin_of(levels, 7), 64'd49);

        do_reset();
        clear_frame(); fr_re[7] = 12'sd26;
        send_frame(1'b1);
        check("setup bin7=5", bin_of(levels, 7), 64'd5);
        fr_re[7] = 12'sd0;  send_frame(1'b1);
        fr_re[7] = 12'sd36; send_frame(1'b0);
        fr_re[7] = 12'sd0;  send_frame(1'b1);
        check("decay+write at 5", bin_of(levels, 7), 64'd10);
`else
        fd_cnt = 0;
        send_frame(1'b1);
        check("zero frame bin0", bin_of(levels, 0), 64'd0);
        check("zero frame all levels", levels, 64'd0);
        check("zero frame frame_done count", 64'(fd_cnt), 64'd1);
        fr_re[7] = 12'sd80;
        send_frame(1'b1);
        check("direct bin7=50", bin_of(levels, 7), 64'd50);
        fr_re[7] = 12'sd36;
        send_frame(1'b1);
        check("direct overwrite bin7=10", bin_of(levels, 7), 64'd10);
`endif

        do_reset();
        for (int k = 0; k < 8; k++) fr_re[k] = 12'sd100;
        send_frame(1'b1);
        check("all bins 78", levels, 64'h4E4E_4E4E_4E4E_4E4E);
        for (int k = 0; k < 4; k++) begin
            ce = 1'b1; sync = (k == 0); in_real = 12'sd2047; in_imag = 12'sd0;
            step();
        end
        #2;
        reset = 1'b1;
        #1;
        check("mid-frame reset levels", levels, 64'd0);
        check("mid-frame reset frame_done", 64'(frame_done), 64'd0);
        ce = 1'b0; sync = 1'b0;
        step();
        reset = 1'b0;
        fd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            ce = 1'b1; sync = 1'b0; in_real = 12'sd2047;
            step();
        end
        ce = 1'b0; in_real = '0;
        step();
        step();
        check("no write before sync", levels, 64'd0);
        check("no frame_done before sync", 64'(fd_cnt), 64'd0);
        clear_frame(); fr_re[0] = 12'sd100;
        send_frame(1'b1);
        check("resume after sync", levels, 64'h0000_0000_0000_004E);
        check("resume frame_done count", 64'(fd_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bin_peak_decay.md
BIN_PEAK_DECAY -- requirements
Module: bin_peak_decay

Interface
REQ-001 SHALL have parameter WIDTH, default 12, FFT output component width (signed).
REQ-002 SHALL have parameter BINS, default 8, number of tracked bins, 1..255.
REQ-003 SHALL have parameter BIN_DIV, default 7, right-shift applied to bin energy.
REQ-004 SHALL have parameter DECAY_DIV, default 4, frames per decay step, >=1.
REQ-005 SHALL have parameter DECAY_STEP, default 1, level decrement per decay step, 0..255.
REQ-006 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port ce  input  1  FFT output sample valid, one bin per asserted cycle.
REQ-009 SHALL have port sync  input  1  qualified by ce; marks bin 0 of a frame.
REQ-010 SHALL have port in_real  input  WIDTH  signed real part.
REQ-011 SHALL have port in_imag  input  WIDTH  signed imaginary part.
REQ-012 SHALL have port levels  output  8*BINS  bin k level at bits [8k+7:8k], unsigned.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after bin BINS-1 is written.

Function
REQ-014 SHALL, on a ce cycle, register energy = in_real^2 + in_imag^2 at full precision (2*WIDTH bits, no overflow) together with its bin index and a valid bit.
REQ-015 SHALL drive the bin index to 0 when ce&sync; otherwise increment it on each ce, saturating at BINS (no wrap).
REQ-016 SHALL treat samples with index >= BINS, and all samples before the first ce&sync after reset, as invalid (no level write).
REQ-017 SHALL, on the cycle after a valid stage-1 result, form scaled = min(energy >> BIN_DIV, 255) and write it to the addressed bin; the write is not gated by ce.
REQ-018 SHALL make a bin-k level change visible on levels two clock edges after the ce cycle carrying bin k.
REQ-019 SHALL, with peak hold, write max(scaled, current level); the level never drops due to a write.
REQ-020 SHALL count ce&sync events modulo DECAY_DIV; on the event that wraps the counter to 0, reduce every bin level by DECAY_STEP, saturating at 0.
REQ-021 SHALL, when a decay and a write hit the same bin on one edge, store max(scaled, sat0(level - DECAY_STEP)).
REQ-022 SHALL pulse frame_done for exactly one cycle, concurrent with the edge that makes bin BINS-1 visible.
REQ-023 SHALL keep unaddressed bin levels unchanged except for decay.

Reset
REQ-024 SHALL, while reset is high, asynchronously clear all levels, frame_done, the pipeline valid bits, the bin index (to BINS, i.e. invalid), the frame-seen flag, and the decay counter.
REQ-025 SHALL discard any in-flight sample when reset is asserted mid-frame; updates resume only after the next ce&sync.

Configuration
REQ-026 SHALL, with macro BIN_PEAK_DECAY_PEAK_HOLD_EN defined, implement the peak-hold and decay behaviour of REQ-019..REQ-021.
REQ-027 SHALL, without BIN_PEAK_DECAY_PEAK_HOLD_EN, write scaled directly (level = scaled), with no decay logic and no decay counter.

Verification
REQ-028 SHALL cover: sync frame with bin 0 in_real=100, in_imag=0 -> levels[7:0]=78 two edges later.
REQ-029 SHALL cover: bin 1 in_real=-100, in_imag=0 -> 78; bin 2 in_real=in_imag=2047 -> 255 (saturated); bin 3 in_real=in_imag=-2048 -> 255.
REQ-030 SHALL cover (PEAK_HOLD_EN, DECAY_DIV=4, DECAY_STEP=1): bin 0 at 78, then zero-input frames -> 78 after 3 syncs, 77 on the 4th, reaching 0 and holding at 0 thereafter; without the macro -> 0 on the next frame.
REQ-031 SHALL cover: samples before any sync, and bins with index >= 8 (e.g. ninth sample in_real=2047) -> levels unchanged; frame_done pulses once per frame, on the bin-7 write.
REQ-032 SHALL cover: reset asserted between bins 3 and 4 -> all levels 0 immediately; later ce without sync -> no writes until the next sync.
REQ-033 SHALL cover: decay edge coinciding with a write of scaled=10 to a bin at level 50 -> 49; at level 5 -> 10.
